mips_multiciclo: RTL and testbench
==================================

# mips_multiciclo

Parametrised multi-cycle MIPS-subset processor core. It is the next generation of the single-cycle ISA datapath. A control FSM sequences every instruction over 3–5 cycles, and one shared ALU computes PC+4, branch targets and data addresses. Instructions and data share one memory port with a request/acknowledge handshake, so wait states are tolerated. It adds `addi`, `j`, `slt`, a halt state and register-0 hardwiring, none of which the single-cycle datapath has.

## Interface
- `DATA_W`, default 32: datapath, register and PC width (≥16).
- `NREG`, default 32: register count (power of two, ≤32); register index = low log2(NREG) bits of the rs/rt/rd field.
- `ADDR_W`, default 16: memory address width; `mem_addr` = low ADDR_W bits of the byte address.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on the `clk` rising edge).
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wdata`  out  DATA_W  store data.
- `mem_rdata`  in  DATA_W  read data; valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  transaction complete.
- `pc_out`  out  DATA_W  current PC.
- `salida`  out  DATA_W  last value written to the register file.
- `halt`  out  1  core stopped on an unsupported opcode.

## Operation
- Supported instructions:
  - R-type (op 0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
  - An unsupported R-type funct writes 0.
- FSM states: FETCH, DECODE, EX_R, EX_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, EX_ADDI, WB_I, BRANCH, JUMP, HALT.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - On `mem_ack`: latch IR; PC ← PC+4 (ALU); go to DECODE.
- DECODE:
  - Read rs/rt into A/B.
  - ALUOut ← PC + (sext(imm)<<2).
  - Dispatch on opcode; any unknown opcode goes to HALT.
- R-type: EX_R computes ALUOut ← A op B; WB_R writes rd.
- addi: EX_ADDI computes ALUOut ← A + sext(imm); WB_I writes rt.
- lw / sw: EX_ADDR computes ALUOut ← A + sext(imm), then:
  - lw: MEM_RD holds the request until ack and latches MDR; WB_MEM writes rt.
  - sw: MEM_WR holds `mem_we`=1, `mem_wdata`=B until ack.
- beq: BRANCH; if A==B then PC ← ALUOut.
- j: JUMP sets PC ← {PC[DATA_W-1:28], IR[25:0], 2'b00}; for DATA_W<32, use the low DATA_W bits.
- Every terminal state returns to FETCH.
- Register 0 always reads 0; writes to it are discarded, but `salida` still updates.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- HALT is absorbing: `halt`=1, `mem_req`=0, PC frozen. Only reset leaves it.

## Timing
- Reset values:
  - PC=0, state FETCH, IR/A/B/ALUOut/MDR=0, all registers 0.
  - `mem_req`=0 in the reset cycle; `salida`=0, `halt`=0.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from assertion until the cycle `mem_ack`=1, inclusive.
  - `mem_req` deasserts in the next state unless the next state also requests.
  - An ack in the same cycle as the request is allowed (zero wait).
  - `mem_ack` while `mem_req`=0 is ignored.
- Cycle counts with zero wait: R / addi 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- `salida` is registered and updates on the same edge as the register-file write; it holds otherwise.
- Reset asserted mid-transaction: the next edge forces FETCH with `mem_req`=0; the pending ack is ignored.

## Structure
- Package `mips_pkg` holds:
  - the opcode and funct localparams;
  - the FSM state enum;
  - the 3-bit ALU-operation enum (ADD, SUB, AND, OR, SLT).
- Sub-module `reg_file`, parametrised by DATA_W and NREG:
  - two async read ports and one sync write port;
  - register 0 hardwired;
  - cleared on the active-low `rst`.

## Test plan
- Zero-wait memory, program `addi $1,$0,5; addi $2,$0,7; add $3,$1,$2`:
  - `salida`=12 after cycle 12;
  - `pc_out`=12.
- `sw $3,0x40($0); lw $4,0x40($0)` with a 2-cycle ack delay:
  - write at 0x40 with data 12;
  - `salida`=12;
  - `mem_req` and `mem_addr` are stable through all wait cycles.
- `beq $1,$1,+2` at PC 0x10 → next fetch address 0x1C; `beq $1,$2` with unequal operands → 0x14.
- `j 0x40` → next fetch at byte address 0x100; `addi $0,$0,9` → $0 still reads 0 and `salida`=9.
- Opcode 0x3F → `halt`=1 and `mem_req` stays 0 for 20 cycles; `rst`=0 asserted during a pending lw → next cycle: FETCH, PC 0, `mem_req`=0 while `rst` is held low.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcodes, function codes, FSM states and ALU operations for the multi-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, EX_R, EX_ADDR, MEM_RD, MEM_WR, WB_R,
        WB_MEM, EX_ADDI, WB_I, BRANCH, JUMP, HALT
    } cpuState;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } aluOpT;

    function automatic aluOpT functToAluOp(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic functKnown(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one clocked write port, register 0 reads as zero.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] rdAddrA,
    input  logic [$clog2(NREG)-1:0] rdAddrB,
    output logic [DATA_W-1:0]       rdDataA,
    output logic [DATA_W-1:0]       rdDataB,
    input  logic                    wrEn,
    input  logic [$clog2(NREG)-1:0] wrAddr,
    input  logic [DATA_W-1:0]       wrData
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (wrAddr != '0)) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = (rdAddrA == '0) ? '0 : regs[rdAddrA];
    assign rdDataB = (rdAddrB == '0) ? '0 : regs[rdAddrB];

endmodule

// File: rtl/mips_multiciclo.sv
// Multi-cycle MIPS-subset core: one shared ALU, one shared memory port with req/ack handshake.
//   state   | meaning
//   FETCH   | read instruction at PC, PC <- PC+4 on ack
//   DECODE  | A/B <- rs/rt, ALUOut <- branch target, dispatch
//   EX_R    | ALUOut <- A op B
//   EX_ADDR | ALUOut <- A + sext(imm) (lw/sw address)
//   MEM_RD  | load request held until ack, MDR latched
//   MEM_WR  | store request held until ack
//   WB_R    | rd <- ALUOut
//   WB_MEM  | rt <- MDR
//   EX_ADDI | ALUOut <- A + sext(imm)
//   WB_I    | rt <- ALUOut
//   BRANCH  | PC <- ALUOut when A == B
//   JUMP    | PC <- {PC[top:28], target, 00}
//   HALT    | unsupported opcode, stopped until reset
module mips_multiciclo #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] salida,
    output logic              halt
);
    import mips_pkg::*;

    localparam int IDX_W = $clog2(NREG);

    cpuState state, nextState;

    logic [DATA_W-1:0] pc, a, b, aluOut, mdr;
    logic [31:0]       ir;
    logic [5:0]        opcode, funct;
    logic [IDX_W-1:0]  rsIdx, rtIdx, rdIdx;
    logic [DATA_W-1:0] sextImm;

    logic [DATA_W-1:0] aluA, aluB, aluRes;
    aluOpT             aluOp;

    logic [DATA_W-1:0] rfDataA, rfDataB, rfWdata;
    logic [IDX_W-1:0]  rfWaddr;
    logic              rfWe;

    logic              memReqInt, memWeInt, addrFromAlu;
    logic [63:0]       rdWide, jmpWide;
    logic [DATA_W-1:0] jmpTarget;
    logic              unusedBits;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign rsIdx   = ir[21 +: IDX_W];
    assign rtIdx   = ir[16 +: IDX_W];
    assign rdIdx   = ir[11 +: IDX_W];
    assign sextImm = DATA_W'($signed(ir[15:0]));
    assign rdWide  = 64'(mem_rdata);

    // Jump keeps PC bits above 27; narrow datapaths simply drop what does not fit.
    always_comb begin
        jmpWide        = 64'(pc);
        jmpWide[27:0]  = {ir[25:0], 2'b00};
    end
    assign jmpTarget = jmpWide[DATA_W-1:0];

    assign unusedBits = ^{ir[10:6], rdWide[63:32], jmpWide[63:DATA_W]};

    reg_file #(.DATA_W(DATA_W), .NREG(NREG)) uRegFile (
        .clk     (clk),
        .rst     (rst),
        .rdAddrA (rsIdx),
        .rdAddrB (rtIdx),
        .rdDataA (rfDataA),
        .rdDataB (rfDataB),
        .wrEn    (rfWe),
        .wrAddr  (rfWaddr),
        .wrData  (rfWdata)
    );

    always_comb begin
        aluA  = pc;
        aluB  = DATA_W'(4);
        aluOp = ALU_ADD;
        case (state)
            DECODE:           aluB = sextImm << 2;
            EX_R: begin
                aluA  = a;
                aluB  = b;
                aluOp = functToAluOp(funct);
            end
            EX_ADDR, EX_ADDI: begin
                aluA = a;
                aluB = sextImm;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (aluOp)
            ALU_ADD: aluRes = aluA + aluB;
            ALU_SUB: aluRes = aluA - aluB;
            ALU_AND: aluRes = aluA & aluB;
            ALU_OR:  aluRes = aluA | aluB;
            ALU_SLT: aluRes = {{(DATA_W-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
            default: aluRes = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        memReqInt   = 1'b0;
        memWeInt    = 1'b0;
        addrFromAlu = 1'b0;
        rfWe        = 1'b0;
        rfWaddr     = rtIdx;
        rfWdata     = aluOut;
        case (state)
            FETCH: begin
                memReqInt = 1'b1;
                if (mem_ack) nextState = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     nextState = EX_R;
                    OP_LW, OP_SW: nextState = EX_ADDR;
                    OP_ADDI:      nextState = EX_ADDI;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    default:      nextState = HALT;
                endcase
            end
            EX_R:    nextState = WB_R;
            EX_ADDI: nextState = WB_I;
            EX_ADDR: nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                memReqInt   = 1'b1;
                addrFromAlu = 1'b1;
                if (mem_ack) nextState = WB_MEM;
            end
            MEM_WR: begin
                memReqInt   = 1'b1;
                memWeInt    = 1'b1;
                addrFromAlu = 1'b1;
                if (mem_ack) nextState = FETCH;
            end
            WB_R: begin
                rfWe      = 1'b1;
                rfWaddr   = rdIdx;
                nextState = FETCH;
            end
            WB_I: begin
                rfWe      = 1'b1;
                nextState = FETCH;
            end
            WB_MEM: begin
                rfWe      = 1'b1;
                rfWdata   = mdr;
                nextState = FETCH;
            end
            BRANCH, JUMP: nextState = FETCH;
            HALT:         nextState = HALT;
            default:      nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluOut <= '0;
            mdr    <= '0;
            salida <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir <= rdWide[31:0];
                        pc <= aluRes;
                    end
                end
                DECODE: begin
                    a      <= rfDataA;
                    b      <= rfDataB;
                    aluOut <= aluRes;
                end
                EX_R:             aluOut <= functKnown(funct) ? aluRes : '0;
                EX_ADDR, EX_ADDI: aluOut <= aluRes;
                MEM_RD:           if (mem_ack) mdr <= mem_rdata;
                BRANCH:           if (a == b) pc <= aluOut;
                JUMP:             pc <= jmpTarget;
                default: ;
            endcase
            if (rfWe) salida <= rfWdata;
        end
    end

    // Outputs are gated by reset so nothing requests memory while reset is held.
    assign mem_req   = memReqInt & rst;
    assign mem_we    = memWeInt & rst;
    assign mem_addr  = addrFromAlu ? ADDR_W'(aluOut) : ADDR_W'(pc);
    assign mem_wdata = b;
    assign pc_out    = pc;
    assign halt      = (state == HALT) & rst;

endmodule

// File: tb/tb_mips_multiciclo.sv
// Directed bench for mips_multiciclo: small programs in a wait-state memory model, hand-computed results.
module tb_mips_multiciclo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ack, halt;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc_out, salida;

    logic [31:0] progArr   [256];
    logic [31:0] dataArr   [256];
    logic        dataValid [256] = '{default: 1'b0};

    int          waitCycles = 0;
    int          waitCnt    = 0;
    int          wrCount    = 0;
    int          stabErr    = 0;
    logic [15:0] lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    logic        inTxn      = 1'b0;
    logic [15:0] txnAddr;
    logic        txnWe;
    logic [31:0] txnWdata;

    int nVec = 0;
    int nErr = 0;

    mips_multiciclo #(.DATA_W(32), .NREG(32), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .salida    (salida),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    // Memory responder: ack after waitCycles idle cycles of a held request.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (waitCnt >= waitCycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = dataValid[mem_addr[9:2]] ? dataArr[mem_addr[9:2]]
                                                         : progArr[mem_addr[9:2]];
                    waitCnt   = 0;
                end else begin
                    mem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                mem_ack = 1'b0;
                waitCnt = 0;
            end
        end
    end

    // Store capture and request-stability watch.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_req) begin
                if (inTxn && (mem_addr != txnAddr || mem_we != txnWe || mem_wdata != txnWdata))
                    stabErr++;
                if (!inTxn) begin
                    txnAddr  = mem_addr;
                    txnWe    = mem_we;
                    txnWdata = mem_wdata;
                    inTxn    = 1'b1;
                end
                if (mem_ack) begin
                    inTxn = 1'b0;
                    if (mem_we) begin
                        dataArr[mem_addr[9:2]]   = mem_wdata;
                        dataValid[mem_addr[9:2]] = 1'b1;
                        lastWrAddr = mem_addr;
                        lastWrData = mem_wdata;
                        wrCount++;
                    end
                end
            end else begin
                inTxn = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rI(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] iI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jI(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic clearProg();
        for (int i = 0; i < 256; i++) progArr[i] = 32'hFC00_0000;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset(input int w);
        @(posedge clk);
        #1 rst = 1'b0;
        waitCycles = w;
        @(negedge clk);
        chk("rst mem_req", mem_req, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst pc", pc_out, 32'h0);
        chk("rst salida", salida, 32'h0);
        chk("rst halt", halt, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    logic [31:0] exp1 [13] = '{32'd5, 32'd7, 32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7, 32'd0,
                               32'd1, 32'd0, 32'd9, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    initial begin
        int reqSeen;

        // Zero-wait ALU program ending in an unsupported opcode.
        clearProg();
        progArr[0]  = iI(6'h08, 0, 1, 16'd5);
        progArr[1]  = iI(6'h08, 0, 2, 16'd7);
        progArr[2]  = rI(1, 2, 3, 6'h20);
        progArr[3]  = rI(1, 2, 5, 6'h22);
        progArr[4]  = rI(1, 2, 6, 6'h24);
        progArr[5]  = rI(1, 2, 7, 6'h25);
        progArr[6]  = rI(1, 5, 9, 6'h2A);
        progArr[7]  = rI(5, 1, 8, 6'h2A);
        progArr[8]  = rI(1, 2, 10, 6'h27);
        progArr[9]  = iI(6'h08, 0, 0, 16'd9);
        progArr[10] = rI(0, 1, 11, 6'h20);
        progArr[11] = iI(6'h08, 0, 12, 16'hFFFF);
        progArr[12] = rI(12, 12, 13, 6'h20);
        progArr[13] = 32'hFC00_0000;
        doReset(0);
        for (int i = 0; i < 13; i++) begin
            ticks(4);
            chk($sformatf("t1 salida[%0d]", i), salida, exp1[i]);
            if (i == 2) chk("t1 pc", pc_out, 32'd12);
        end
        ticks(2);
        chk("t1 halt", halt, 1'b1);
        chk("t1 halt pc", pc_out, 32'h38);
        reqSeen = 0;
        for (int i = 0; i < 20; i++) begin
            ticks(1);
            if (mem_req) reqSeen++;
        end
        chk("t1 halt req cycles", reqSeen, 0);
        chk("t1 halt pc frozen", pc_out, 32'h38);

        // Store then load with two wait cycles on every access.
        clearProg();
        progArr[0] = iI(6'h08, 0, 3, 16'd12);
        progArr[1] = iI(6'h2B, 0, 3, 16'h0040);
        progArr[2] = iI(6'h08, 0, 5, 16'd1);
        progArr[3] = iI(6'h23, 0, 4, 16'h0040);
        doReset(2);
        ticks(6);
        chk("t2 addi salida", salida, 32'd12);
        ticks(8);
        chk("t2 sw count", wrCount, 1);
        chk("t2 sw addr", lastWrAddr, 16'h0040);
        chk("t2 sw data", lastWrData, 32'd12);
        ticks(6);
        chk("t2 addi2 salida", salida, 32'd1);
        ticks(5);
        chk("t2 lw req w0", mem_req, 1'b1);
        chk("t2 lw addr w0", mem_addr, 16'h0040);
        chk("t2 lw we", mem_we, 1'b0);
        ticks(1);
        chk("t2 lw req w1", mem_req, 1'b1);
        chk("t2 lw addr w1", mem_addr, 16'h0040);
        ticks(1);
        chk("t2 lw req w2", mem_req, 1'b1);
        chk("t2 lw addr w2", mem_addr, 16'h0040);
        ticks(2);
        chk("t2 lw salida", salida, 32'd12);
        chk("t2 pc", pc_out, 32'h10);
        chk("t2 stability", stabErr, 0);
        ticks(4);
        chk("t2 halt", halt, 1'b1);

        // Branch taken / not taken at 0x10, then jump.
        for (int run = 0; run < 2; run++) begin
            clearProg();
            progArr[0] = iI(6'h08, 0, 1, 16'd5);
            progArr[1] = iI(6'h08, 0, 2, 16'd7);
            progArr[2] = rI(1, 2, 3, 6'h20);
            progArr[3] = rI(1, 1, 4, 6'h20);
            if (run == 0) begin
                progArr[4]  = iI(6'h04, 1, 1, 16'd2);
                progArr[7]  = jI(26'h40);
                progArr[64] = iI(6'h08, 0, 5, 16'h0077);
            end else begin
                progArr[4] = iI(6'h04, 1, 2, 16'd2);
                progArr[5] = iI(6'h08, 0, 6, 16'h0055);
            end
            doReset(0);
            ticks(16);
            chk("t3 add salida", salida, 32'd10);
            ticks(3);
            if (run == 0) begin
                chk("t3 beq taken pc", pc_out, 32'h1C);
                chk("t3 beq taken addr", mem_addr, 16'h001C);
                chk("t3 beq taken req", mem_req, 1'b1);
                ticks(3);
                chk("t3 j pc", pc_out, 32'h100);
                chk("t3 j addr", mem_addr, 16'h0100);
                ticks(4);
                chk("t3 after j salida", salida, 32'h77);
            end else begin
                chk("t3 beq untaken pc", pc_out, 32'h14);
                chk("t3 beq untaken addr", mem_addr, 16'h0014);
                ticks(4);
                chk("t3 fallthrough salida", salida, 32'h55);
            end
            ticks(2);
            chk("t3 halt", halt, 1'b1);
        end

        // Reset while a load is waiting for its ack.
        clearProg();
        progArr[0] = iI(6'h23, 0, 4, 16'h0040);
        doReset(5);
        ticks(8);
        chk("t4 lw pending req", mem_req, 1'b1);
        chk("t4 lw pending addr", mem_addr, 16'h0040);
        ticks(2);
        chk("t4 still pending", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("t4 req drop", mem_req, 1'b0);
        ticks(1);
        chk("t4 rst pc", pc_out, 32'h0);
        chk("t4 rst req", mem_req, 1'b0);
        chk("t4 rst halt", halt, 1'b0);
        ticks(1);
        chk("t4 rst req held", mem_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        ticks(5);
        chk("t4 refetch req", mem_req, 1'b1);
        chk("t4 refetch pc", pc_out, 32'h0);
        ticks(1);
        chk("t4 refetch done pc", pc_out, 32'h4);
        chk("t4 salida", salida, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", nVec);
        $fatal(1, "watchdog");
    end

endmodule
